// File: rtl/bp_cac_io_master_if.sv
// Host and I/O-side signal bundle for bp_cac_io_master.
// master: the bridge itself; slave: the host plus accelerator environment.
interface bp_cac_io_master_if #(
    parameter int unsigned paddr_width_p = 40,
    parameter int unsigned dword_width_p = 64,
    parameter int unsigned msg_width_p   = 575
);
    logic                     host_v_i;
    logic                     host_w_i;
    logic [paddr_width_p-1:0] host_addr_i;
    logic [dword_width_p-1:0] host_data_i;
    logic                     host_ready_o;
    logic                     host_resp_v_o;
    logic [dword_width_p-1:0] host_resp_data_o;
    logic                     host_resp_err_o;
    logic                     host_resp_yumi_i;
    logic [msg_width_p-1:0]   io_cmd_o;
    logic                     io_cmd_v_o;
    logic                     io_cmd_ready_i;
    logic [msg_width_p-1:0]   io_resp_i;
    logic                     io_resp_v_i;
    logic                     io_resp_yumi_o;

    modport master (
        input  host_v_i, host_w_i, host_addr_i, host_data_i, host_resp_yumi_i,
        input  io_cmd_ready_i, io_resp_i, io_resp_v_i,
        output host_ready_o, host_resp_v_o, host_resp_data_o, host_resp_err_o,
        output io_cmd_o, io_cmd_v_o, io_resp_yumi_o
    );

    modport slave (
        output host_v_i, host_w_i, host_addr_i, host_data_i, host_resp_yumi_i,
        output io_cmd_ready_i, io_resp_i, io_resp_v_i,
        input  host_ready_o, host_resp_v_o, host_resp_data_o, host_resp_err_o,
        input  io_cmd_o, io_cmd_v_o, io_resp_yumi_o
    );
endinterface

// File: rtl/bp_cac_io_master.sv
// bp_cac_io_master: single-outstanding uncached I/O master that turns host
// read/write requests into CCE memory messages and returns completions,
// with a response timeout and draining of responses that arrive too late.
package bp_cac_io_pkg;
    typedef enum logic [1:0] { e_bp_inv_cfg = 2'd0 } bp_params_e;

    localparam int unsigned inv_paddr_width_gp     = 40;
    localparam int unsigned inv_dword_width_gp     = 64;
    localparam int unsigned inv_cce_block_width_gp = 512;

    function automatic int unsigned paddr_width_f(bp_params_e cfg);
        case (cfg)
            e_bp_inv_cfg: return inv_paddr_width_gp;
            default:      return inv_paddr_width_gp;
        endcase
    endfunction

    function automatic int unsigned dword_width_f(bp_params_e cfg);
        case (cfg)
            e_bp_inv_cfg: return inv_dword_width_gp;
            default:      return inv_dword_width_gp;
        endcase
    endfunction

    function automatic int unsigned cce_block_width_f(bp_params_e cfg);
        case (cfg)
            e_bp_inv_cfg: return inv_cce_block_width_gp;
            default:      return inv_cce_block_width_gp;
        endcase
    endfunction

    typedef enum logic [3:0] {
        e_cce_mem_rd    = 4'd0,
        e_cce_mem_wr    = 4'd1,
        e_cce_mem_uc_rd = 4'd2,
        e_cce_mem_uc_wr = 4'd3,
        e_cce_mem_pre   = 4'd4
    } bp_cce_mem_cmd_type_e;

    typedef enum logic [2:0] {
        e_mem_size_1  = 3'd0,
        e_mem_size_2  = 3'd1,
        e_mem_size_4  = 3'd2,
        e_mem_size_8  = 3'd3,
        e_mem_size_16 = 3'd4,
        e_mem_size_32 = 3'd5,
        e_mem_size_64 = 3'd6
    } bp_mem_msg_size_e;

    typedef struct packed {
        bp_cce_mem_cmd_type_e          msg_type;
        logic [15:0]                   payload;
        bp_mem_msg_size_e              size;
        logic [inv_paddr_width_gp-1:0] addr;
    } bp_cce_mem_msg_header_s;

    typedef struct packed {
        bp_cce_mem_msg_header_s            header;
        logic [inv_cce_block_width_gp-1:0] data;
    } bp_cce_mem_msg_s;
endpackage

module bp_cac_io_master
    import bp_cac_io_pkg::*;
#(
    parameter bp_params_e  bp_params_p      = e_bp_inv_cfg,
    parameter int unsigned timeout_cycles_p = 1024
) (
    input logic                clk_i,
    input logic                reset_i,
    bp_cac_io_master_if.master bus
);
    localparam int unsigned paddr_width_lp = paddr_width_f(bp_params_p);
    localparam int unsigned dword_width_lp = dword_width_f(bp_params_p);
    localparam int unsigned block_width_lp = cce_block_width_f(bp_params_p);
    localparam int unsigned cnt_width_lp   = $clog2(timeout_cycles_p);
    localparam logic [cnt_width_lp-1:0] cnt_last_lp = cnt_width_lp'(timeout_cycles_p - 1);

    typedef enum logic [1:0] { e_idle, e_send, e_wait, e_reply } state_e;

    state_e                    state_r, state_n;
    logic                      w_r, w_n;
    logic [paddr_width_lp-1:0] addr_r, addr_n;
    logic [dword_width_lp-1:0] data_r, data_n;
    logic [dword_width_lp-1:0] resp_data_r, resp_data_n;
    logic                      resp_err_r, resp_err_n;
    logic [cnt_width_lp-1:0]   cnt_r, cnt_n;
    logic                      stale_r, stale_n;

    bp_cce_mem_msg_s cmd, resp;
    logic            unused_resp_bits;

    assign resp = bus.io_resp_i;
    assign unused_resp_bits = ^{resp.header.payload, resp.header.size, resp.header.addr,
                                resp.data[block_width_lp-1:dword_width_lp]};

    // Command image is rebuilt from the latched request so it stays constant in e_send.
    always_comb begin
        cmd                 = '0;
        cmd.header.msg_type = w_r ? e_cce_mem_uc_wr : e_cce_mem_uc_rd;
        cmd.header.size     = e_mem_size_8;
        cmd.header.addr     = addr_r;
        if (w_r) begin
            cmd.data[dword_width_lp-1:0] = data_r;
        end
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r     <= e_idle;
            w_r         <= 1'b0;
            addr_r      <= '0;
            data_r      <= '0;
            resp_data_r <= '0;
            resp_err_r  <= 1'b0;
            cnt_r       <= '0;
            stale_r     <= 1'b0;
        end else begin
            state_r     <= state_n;
            w_r         <= w_n;
            addr_r      <= addr_n;
            data_r      <= data_n;
            resp_data_r <= resp_data_n;
            resp_err_r  <= resp_err_n;
            cnt_r       <= cnt_n;
            stale_r     <= stale_n;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_n     = state_r;
        w_n         = w_r;
        addr_n      = addr_r;
        data_n      = data_r;
        resp_data_n = resp_data_r;
        resp_err_n  = resp_err_r;
        cnt_n       = cnt_r;
        stale_n     = stale_r;

        bus.host_ready_o     = 1'b0;
        bus.host_resp_v_o    = 1'b0;
        bus.host_resp_data_o = '0;
        bus.host_resp_err_o  = 1'b0;
        bus.io_cmd_o         = '0;
        bus.io_cmd_v_o       = 1'b0;
        bus.io_resp_yumi_o   = 1'b0;

        unique case (state_r)
            e_idle: begin
                bus.host_ready_o   = 1'b1;
                bus.io_resp_yumi_o = bus.io_resp_v_i;
                if (bus.io_resp_v_i) begin
                    stale_n = 1'b0;
                end
                if (bus.host_v_i) begin
                    w_n     = bus.host_w_i;
                    addr_n  = bus.host_addr_i;
                    data_n  = bus.host_data_i;
                    state_n = e_send;
                end
            end
            e_send: begin
                bus.io_cmd_v_o = 1'b1;
                bus.io_cmd_o   = cmd;
                // Only a response owed to a timed-out transaction is taken here.
                if (stale_r && bus.io_resp_v_i) begin
                    bus.io_resp_yumi_o = 1'b1;
                    stale_n            = 1'b0;
                end
                if (bus.io_cmd_ready_i) begin
                    cnt_n   = '0;
                    state_n = e_wait;
                end
            end
            e_wait: begin
                bus.io_resp_yumi_o = bus.io_resp_v_i;
                // A live response beats a timeout landing on the same cycle.
                if (bus.io_resp_v_i && !stale_r) begin
                    state_n = e_reply;
                    if (resp.header.msg_type != cmd.header.msg_type) begin
                        resp_data_n = '0;
                        resp_err_n  = 1'b1;
                    end else begin
                        resp_data_n = w_r ? '0 : resp.data[dword_width_lp-1:0];
                        resp_err_n  = 1'b0;
                    end
                end else begin
                    if (bus.io_resp_v_i) begin
                        stale_n = 1'b0;
                    end
                    if (cnt_r == cnt_last_lp) begin
                        resp_data_n = '1;
                        resp_err_n  = 1'b1;
                        stale_n     = 1'b1;
                        state_n     = e_reply;
                    end else begin
                        cnt_n = cnt_r + 1'b1;
                    end
                end
            end
            e_reply: begin
                bus.host_resp_v_o    = 1'b1;
                bus.host_resp_data_o = resp_data_r;
                bus.host_resp_err_o  = resp_err_r;
                bus.io_resp_yumi_o   = bus.io_resp_v_i;
                if (bus.io_resp_v_i) begin
                    stale_n = 1'b0;
                end
                if (bus.host_resp_yumi_i) begin
                    state_n = e_idle;
                end
            end
            default: state_n = e_idle;
        endcase

        // State is already e_idle during reset; these two would otherwise follow it.
        if (reset_i) begin
            bus.host_ready_o   = 1'b0;
            bus.io_resp_yumi_o = 1'b0;
        end
    end
endmodule

// File: tb/tb_bp_cac_io_master.sv
// Self-checking bench for bp_cac_io_master: directed scenarios followed by
// randomized transactions, checked against a transaction-level model.
module tb_bp_cac_io_master;
    import bp_cac_io_pkg::*;

    localparam int unsigned to_lp = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bp_cac_io_master_if #(
        .paddr_width_p(40),
        .dword_width_p(64),
        .msg_width_p($bits(bp_cce_mem_msg_s))
    ) bus ();

    bp_cac_io_master #(
        .bp_params_p(e_bp_inv_cfg),
        .timeout_cycles_p(to_lp)
    ) dut (
        .clk_i(clk),
        .reset_i(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit model_stale = 1'b0;

    task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Expected command for a request, straight from the message format rules.
    function automatic bp_cce_mem_msg_s ref_cmd(input bit w, input logic [39:0] a, input logic [63:0] d);
        bp_cce_mem_msg_s m;
        m = '0;
        m.header.msg_type = w ? e_cce_mem_uc_wr : e_cce_mem_uc_rd;
        m.header.size     = e_mem_size_8;
        m.header.addr     = a;
        if (w) m.data[63:0] = d;
        return m;
    endfunction

    // Expected {err, data} for a completed (non-timeout) transaction.
    function automatic logic [64:0] ref_done(input bit w, input bp_cce_mem_cmd_type_e rt, input logic [63:0] rd);
        bp_cce_mem_cmd_type_e want;
        want = w ? e_cce_mem_uc_wr : e_cce_mem_uc_rd;
        if (rt != want) return {1'b1, 64'h0};
        return {1'b0, (w ? 64'h0 : rd)};
    endfunction

    function automatic bp_cce_mem_msg_s junk_msg();
        bp_cce_mem_msg_s m;
        m = '0;
        m.header.msg_type = bp_cce_mem_cmd_type_e'($urandom_range(0, 3));
        m.data[63:0]      = {$urandom, $urandom};
        return m;
    endfunction

    task automatic clear_inputs();
        bus.host_v_i         = 1'b0;
        bus.host_w_i         = 1'b0;
        bus.host_addr_i      = '0;
        bus.host_data_i      = '0;
        bus.host_resp_yumi_i = 1'b0;
        bus.io_cmd_ready_i   = 1'b0;
        bus.io_resp_i        = '0;
        bus.io_resp_v_i      = 1'b0;
    endtask

    // One transaction from idle back to idle.
    // drain_at: where an owed late response is injected (0 idle, 1 send, 2 wait).
    task automatic run_txn(input bit w, input logic [39:0] addr, input logic [63:0] data,
                           input int stall, input int delay, input bit timeout,
                           input bp_cce_mem_cmd_type_e rtype, input logic [63:0] rdata,
                           input int hold, input int drain_at, input bit reply_drain);
        bp_cce_mem_msg_s exp_cmd, rsp;
        logic [64:0] exp;
        exp_cmd = ref_cmd(w, addr, data);

        settle();
        chk("idle_ready", bus.host_ready_o, 1'b1);
        chk("idle_resp_v", bus.host_resp_v_o, 1'b0);
        if (model_stale && drain_at == 0) begin
            bus.io_resp_i   = junk_msg();
            bus.io_resp_v_i = 1'b1;
            settle();
            chk("idle_drain_yumi", bus.io_resp_yumi_o, 1'b1);
            tick();
            bus.io_resp_v_i = 1'b0;
            model_stale     = 1'b0;
        end

        bus.host_v_i    = 1'b1;
        bus.host_w_i    = w;
        bus.host_addr_i = addr;
        bus.host_data_i = data;
        tick();
        bus.host_v_i = 1'b0;

        for (int i = 0; i <= stall; i++) begin
            bus.io_cmd_ready_i = (i == stall);
            if (i == 0 && model_stale && drain_at == 1) begin
                bus.io_resp_i   = junk_msg();
                bus.io_resp_v_i = 1'b1;
                settle();
                chk("send_drain_yumi", bus.io_resp_yumi_o, 1'b1);
                model_stale = 1'b0;
            end else begin
                settle();
            end
            chk("send_cmd_v", bus.io_cmd_v_o, 1'b1);
            chk("send_cmd", bus.io_cmd_o, exp_cmd);
            chk("send_ready", bus.host_ready_o, 1'b0);
            tick();
            bus.io_resp_v_i = 1'b0;
        end
        bus.io_cmd_ready_i = 1'b0;

        if (model_stale) begin
            bus.io_resp_i   = junk_msg();
            bus.io_resp_v_i = 1'b1;
            settle();
            chk("wait_drain_yumi", bus.io_resp_yumi_o, 1'b1);
            tick();
            bus.io_resp_v_i = 1'b0;
            model_stale     = 1'b0;
            settle();
            chk("wait_after_drain", bus.host_resp_v_o, 1'b0);
        end

        if (timeout) begin
            for (int i = 0; i < int'(to_lp); i++) begin
                settle();
                chk("wait_pending", bus.host_resp_v_o, 1'b0);
                tick();
            end
            exp         = {1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
            model_stale = 1'b1;
        end else begin
            for (int i = 0; i < delay; i++) begin
                settle();
                chk("wait_pending", bus.host_resp_v_o, 1'b0);
                chk("wait_cmd_v", bus.io_cmd_v_o, 1'b0);
                tick();
            end
            rsp = '0;
            rsp.header.msg_type = rtype;
            rsp.header.addr     = addr;
            rsp.data[127:0]     = {$urandom, $urandom, rdata};
            bus.io_resp_i   = rsp;
            bus.io_resp_v_i = 1'b1;
            settle();
            chk("wait_yumi", bus.io_resp_yumi_o, 1'b1);
            tick();
            bus.io_resp_v_i = 1'b0;
            bus.io_resp_i   = junk_msg();
            exp = ref_done(w, rtype, rdata);
        end

        for (int i = 0; i <= hold; i++) begin
            bus.host_resp_yumi_i = (i == hold);
            if (i == 0 && reply_drain && model_stale) begin
                bus.io_resp_i   = junk_msg();
                bus.io_resp_v_i = 1'b1;
                settle();
                chk("reply_drain_yumi", bus.io_resp_yumi_o, 1'b1);
                model_stale = 1'b0;
            end else begin
                settle();
            end
            chk("reply_v", bus.host_resp_v_o, 1'b1);
            chk("reply_data", bus.host_resp_data_o, exp[63:0]);
            chk("reply_err", bus.host_resp_err_o, exp[64]);
            chk("reply_ready", bus.host_ready_o, 1'b0);
            tick();
            bus.io_resp_v_i = 1'b0;
        end
        bus.host_resp_yumi_i = 1'b0;
        settle();
        chk("back_to_idle", bus.host_ready_o, 1'b1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, bus.host_ready_o, 1'b0);
        chk({tag, "_resp_v"}, bus.host_resp_v_o, 1'b0);
        chk({tag, "_resp_data"}, bus.host_resp_data_o, 64'h0);
        chk({tag, "_resp_err"}, bus.host_resp_err_o, 1'b0);
        chk({tag, "_cmd_v"}, bus.io_cmd_v_o, 1'b0);
        chk({tag, "_cmd"}, bus.io_cmd_o, 640'h0);
        chk({tag, "_yumi"}, bus.io_resp_yumi_o, 1'b0);
    endtask

    initial begin
        bit w, tmo, rdr;
        int stall, delay, hold, dat;
        logic [63:0] r_addr, r_data, r_rdata;
        bp_cce_mem_cmd_type_e rtype;

        clear_inputs();
        bus.io_resp_v_i = 1'b1;
        #1;
        chk_all_zero("reset");
        tick();
        tick();
        bus.io_resp_v_i = 1'b0;
        rst = 1'b0;
        tick();

        // Read with response three cycles into the wait.
        run_txn(1'b0, 40'h40_0000_0010, 64'h0, 0, 3, 1'b0, e_cce_mem_uc_rd,
                64'hDEAD_BEEF_CAFE_F00D, 0, 0, 1'b0);
        tick();
        // Write with command backpressure for five cycles.
        run_txn(1'b1, 40'h00_0000_2000, 64'h1234, 5, 2, 1'b0, e_cce_mem_uc_wr,
                64'h5555_AAAA_5555_AAAA, 0, 0, 1'b0);
        // Timeout, then the late response lands in the next read's wait.
        run_txn(1'b0, 40'h12_3456_7890, 64'h0, 0, 0, 1'b1, e_cce_mem_uc_rd, 64'h0, 0, 0, 1'b0);
        run_txn(1'b0, 40'h12_3456_7898, 64'h0, 1, 2, 1'b0, e_cce_mem_uc_rd,
                64'h0123_4567_89AB_CDEF, 0, 2, 1'b0);
        // Read answered with a write response.
        run_txn(1'b0, 40'h00_0000_0100, 64'h0, 0, 1, 1'b0, e_cce_mem_uc_wr,
                64'hFFFF_0000_FFFF_0000, 0, 0, 1'b0);
        // Completion held for ten cycles.
        run_txn(1'b0, 40'h00_0000_0200, 64'h0, 0, 0, 1'b0, e_cce_mem_uc_rd,
                64'h1111_2222_3333_4444, 10, 0, 1'b0);
        // Response on the last counted cycle wins; no stale flag afterwards.
        run_txn(1'b1, 40'h00_0000_0300, 64'hABCD, 0, int'(to_lp) - 1, 1'b0, e_cce_mem_uc_wr,
                64'h0, 0, 0, 1'b0);
        run_txn(1'b0, 40'h00_0000_0308, 64'h0, 0, 0, 1'b0, e_cce_mem_uc_rd,
                64'h7777_8888_9999_AAAA, 0, 0, 1'b0);
        // Late responses drained in idle, send and reply.
        run_txn(1'b0, 40'h1, 64'h0, 0, 0, 1'b1, e_cce_mem_uc_rd, 64'h0, 0, 0, 1'b0);
        run_txn(1'b0, 40'h2, 64'h0, 0, 1, 1'b0, e_cce_mem_uc_rd, 64'h2222, 0, 0, 1'b0);
        run_txn(1'b1, 40'h3, 64'h33, 0, 0, 1'b1, e_cce_mem_uc_wr, 64'h0, 0, 0, 1'b0);
        run_txn(1'b0, 40'h4, 64'h0, 2, 1, 1'b0, e_cce_mem_uc_rd, 64'h4444, 0, 1, 1'b0);
        run_txn(1'b0, 40'h5, 64'h0, 0, 0, 1'b1, e_cce_mem_uc_rd, 64'h0, 2, 0, 1'b1);
        run_txn(1'b0, 40'h6, 64'h0, 0, 0, 1'b0, e_cce_mem_uc_rd, 64'h6666, 0, 0, 1'b0);

        // Reset while waiting for a response; the late response drains in idle.
        bus.host_v_i    = 1'b1;
        bus.host_w_i    = 1'b0;
        bus.host_addr_i = 40'h99;
        tick();
        bus.host_v_i       = 1'b0;
        bus.io_cmd_ready_i = 1'b1;
        tick();
        bus.io_cmd_ready_i = 1'b0;
        tick();
        rst = 1'b1;
        bus.io_resp_i   = junk_msg();
        bus.io_resp_v_i = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        tick();
        rst = 1'b0;
        settle();
        chk("post_reset_ready", bus.host_ready_o, 1'b1);
        chk("post_reset_drain", bus.io_resp_yumi_o, 1'b1);
        tick();
        bus.io_resp_v_i = 1'b0;
        model_stale     = 1'b0;
        run_txn(1'b0, 40'h9A, 64'h0, 0, 1, 1'b0, e_cce_mem_uc_rd, 64'hBEEF, 0, 0, 1'b0);

        // Randomized transactions.
        for (int n = 0; n < 40; n++) begin
            w       = 1'($urandom_range(0, 1));
            r_addr  = {$urandom, $urandom};
            r_data  = {$urandom, $urandom};
            r_rdata = {$urandom, $urandom};
            stall   = int'($urandom_range(0, 3));
            hold    = int'($urandom_range(0, 2));
            dat     = model_stale ? int'($urandom_range(0, 2)) : 0;
            tmo     = ($urandom_range(0, 5) == 0) && !(model_stale && dat == 2);
            delay   = int'($urandom_range(0, (model_stale && dat == 2) ? 5 : int'(to_lp) - 1));
            rdr     = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) rtype = bp_cce_mem_cmd_type_e'($urandom_range(0, 3));
            else                           rtype = w ? e_cce_mem_uc_wr : e_cce_mem_uc_rd;
            run_txn(w, r_addr[39:0], r_data, stall, delay, tmo, rtype, r_rdata, hold, dat, rdr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bp_cac_io_master.md
BP_CAC_IO_MASTER -- requirements
Module: bp_cac_io_master

Interface
REQ-001 SHALL have parameter bp_params_p, default e_bp_inv_cfg, selecting paddr_width_p, dword_width_p and cce_block_width_p via declare_bp_proc_params.
REQ-002 SHALL have parameter timeout_cycles_p, default 1024, setting the maximum e_wait cycles before error completion; legal values are 2 or more.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk_i  in  1  sole clock, all state on rising edge.
REQ-004 reset_i  in  1  asynchronous active-high reset.
REQ-005 host_v_i  in  1  host request valid.
REQ-006 host_w_i  in  1  1 = write, 0 = read.
REQ-007 host_addr_i  in  paddr_width_p  target physical address.
REQ-008 host_data_i  in  dword_width_p  write data.
REQ-009 host_ready_o  out  1  request accepted when host_v_i & host_ready_o.
REQ-010 host_resp_v_o  out  1  completion valid.
REQ-011 host_resp_data_o  out  dword_width_p  read data (0 for writes).
REQ-012 host_resp_err_o  out  1  completion is a timeout or mismatch error.
REQ-013 host_resp_yumi_i  in  1  host consumes completion; legal only when host_resp_v_o=1.
REQ-014 io_cmd_o  out  bp_cce_mem_msg_s width  uncached command toward the accelerator.
REQ-015 io_cmd_v_o  out  1  command valid.
REQ-016 io_cmd_ready_i  in  1  command accepted when io_cmd_v_o & io_cmd_ready_i.
REQ-017 io_resp_i  in  bp_cce_mem_msg_s width  response from the accelerator.
REQ-018 io_resp_v_i  in  1  response valid.
REQ-019 io_resp_yumi_o  out  1  response consumed this cycle.

Function
REQ-020 SHALL implement FSM e_idle, e_send, e_wait, e_reply, with one transaction outstanding at most.
REQ-021 host_ready_o SHALL be 1 only in e_idle; on acceptance, w/addr/data SHALL be latched and the FSM SHALL move to e_send.
REQ-022 In e_send, io_cmd_v_o=1 with io_cmd_o held constant; header.msg_type = e_cce_mem_uc_wr (write) or e_cce_mem_uc_rd (read); header.size = e_mem_size_8; header.addr = latched addr; data = latched data zero-extended (write) or 0 (read); all other fields 0.
REQ-023 On io_cmd_v_o & io_cmd_ready_i, the FSM SHALL enter e_wait and clear the timeout counter; io_cmd_v_o SHALL never deassert before the handshake.
REQ-024 In e_wait, io_resp_yumi_o SHALL equal io_resp_v_i; a response on an unflagged cycle SHALL be captured and the FSM SHALL move to e_reply.
REQ-025 Captured read: data = io_resp_i.data[dword_width_p-1:0], err=0. Captured write: data=0, err=0. If the response msg_type differs from the command msg_type, err=1 and data=0.
REQ-026 The timeout counter SHALL increment each e_wait cycle with no response. On reaching timeout_cycles_p-1, the FSM SHALL enter e_reply with err=1 and data all-ones, and SHALL set the stale flag.
REQ-027 While the stale flag is set, the first io_resp consumed in e_send or e_wait SHALL be discarded, clear the flag, and cause no state change.
REQ-028 In e_idle and e_reply, io_resp_yumi_o SHALL equal io_resp_v_i; those responses SHALL be discarded, and each one SHALL also clear the stale flag.
REQ-029 In e_reply, host_resp_v_o=1 with data and err stable; on host_resp_yumi_i the FSM SHALL return to e_idle.
REQ-030 Latency: request accepted at cycle 0 gives io_cmd_v_o=1 at cycle 1; a response consumed at cycle N gives host_resp_v_o=1 at cycle N+1.
REQ-031 A response arriving in the same cycle the counter reaches timeout_cycles_p-1 SHALL win: normal completion, stale flag unchanged.

Reset
REQ-032 While reset_i=1, asynchronously: state = e_idle, stale flag = 0, counter = 0, latched fields = 0.
REQ-033 During reset: host_ready_o=0, host_resp_v_o=0, host_resp_data_o=0, host_resp_err_o=0, io_cmd_v_o=0, io_cmd_o=0, io_resp_yumi_o=0.
REQ-034 Reset asserted mid-transaction SHALL abandon the transaction. A late response arriving after reset is drained in e_idle.

Verification
REQ-035 Read: addr=0x40_0000_0010; ready_i=1; response uc_rd with data 0xDEADBEEF_CAFEF00D 3 cycles later -> host_resp_data_o=0xDEADBEEF_CAFEF00D, err=0.
REQ-036 Write: data=0x1234, io_cmd_ready_i held low 5 cycles -> io_cmd_o stable and v=1 throughout; uc_wr response -> data=0, err=0.
REQ-037 Timeout: timeout_cycles_p=8, no response -> err=1, data=all-ones after 8 e_wait cycles. Late response during the next read's e_wait -> discarded; the following response completes the read.
REQ-038 Mismatch: read issued, uc_wr response returned -> err=1, data=0.
REQ-039 Backpressure and reset: host_resp_yumi_i held low 10 cycles -> outputs stable and host_ready_o=0. Reset asserted in e_wait -> all outputs 0 immediately, host_ready_o=1 after release.
